// File: rtl/mem_bus_host_master.sv
// Host-side second master on the nibble memory bus: byte bursts to/from the host after bus_gnt.
// Optional MEM_BUS_IO_READ_GUARD_EN: reads of 0xF00-0xF02 never reach the bus and return nibble 0.
module mem_bus_host_master #(
  parameter int RD_LATENCY  = 1,
  parameter int GNT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [11:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        abort,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [11:0] mem_addr,
  output logic        mem_write_en,
  output logic [3:0]  mem_write_data,
  input  logic [3:0]  mem_read_data,
  output logic [3:0]  state_dbg
);
  // Handshakes: a transfer happens on the rising edge where valid && ready are both high.

  typedef enum logic [3:0] {
    IDLE, REQ, RD_ADDR, RD_WAIT, RD_HOLD, WR_WAIT, WR_LO, WR_HI, DONE
  } state_t;

  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int GW = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;

  state_t          state, state_nxt;
  logic [11:0]     ptr, ptr_nxt;
  logic [8:0]      cnt;
  logic [LW-1:0]   lat;
  logic [GW-1:0]   gcnt;
  logic            dir_wr, stop_q, lost_q, aborted_q, phase_hi, guard_q, guard_nxt;
  logic [3:0]      wr_hi, nib;
  logic            owning, gnt_lost, lost, stop, accept, sample, byte_end, capture;

  assign owning    = state inside {RD_ADDR, RD_WAIT, RD_HOLD, WR_WAIT, WR_LO, WR_HI};
  assign gnt_lost  = owning && !bus_gnt;
  assign lost      = lost_q || gnt_lost;
  assign stop      = stop_q || abort || lost;
  assign cmd_ready = reset_n && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE) && (state != DONE);
  assign bus_req   = busy;
  assign done      = (state == DONE);
  assign aborted   = done && aborted_q;
  assign rd_valid  = (state == RD_HOLD);
  assign wr_ready  = (state == WR_WAIT) && wr_valid && !stop;
  assign state_dbg = state;
  assign nib       = guard_q ? 4'h0 : mem_read_data;

`ifdef MEM_BUS_IO_READ_GUARD_EN
  assign guard_nxt = (ptr_nxt >= 12'hF00) && (ptr_nxt <= 12'hF02);
`else
  assign guard_nxt = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sample    = 1'b0;
    byte_end  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_nxt = REQ;
        ptr_nxt   = cmd_addr;
      end
      REQ: begin
        if (bus_gnt) state_nxt = dir_wr ? WR_WAIT : RD_ADDR;
        else if (stop) state_nxt = DONE;
        else if (GNT_TIMEOUT != 0 && gcnt == GW'(GNT_TIMEOUT - 1)) state_nxt = DONE;
      end
      RD_ADDR: begin
        if (RD_LATENCY == 0) sample = 1'b1;
        else state_nxt = RD_WAIT;
      end
      RD_WAIT: if (lat == LW'(RD_LATENCY - 1)) sample = 1'b1;
      RD_HOLD: if (rd_ready) begin
        byte_end  = 1'b1;
        state_nxt = (cnt == 9'd1 || stop) ? DONE : RD_ADDR;
      end
      WR_WAIT: begin
        if (stop) state_nxt = DONE;
        else if (wr_valid) begin
          capture   = 1'b1;
          state_nxt = WR_LO;
        end
      end
      WR_LO: begin
        ptr_nxt   = ptr + 12'd1;
        state_nxt = lost ? DONE : WR_HI;
      end
      WR_HI: begin
        ptr_nxt   = ptr + 12'd1;
        byte_end  = 1'b1;
        state_nxt = (cnt == 9'd1 || stop) ? DONE : WR_WAIT;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A finished nibble read advances the pointer; losing the grant ends the command here.
    if (sample) begin
      ptr_nxt = ptr + 12'd1;
      if (lost) state_nxt = DONE;
      else if (!phase_hi) state_nxt = RD_ADDR;
      else state_nxt = RD_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      ptr            <= '0;
      cnt            <= '0;
      lat            <= '0;
      gcnt           <= '0;
      dir_wr         <= 1'b0;
      stop_q         <= 1'b0;
      lost_q         <= 1'b0;
      aborted_q      <= 1'b0;
      phase_hi       <= 1'b0;
      guard_q        <= 1'b0;
      wr_hi          <= '0;
      rd_data        <= '0;
      mem_addr       <= '0;
      mem_write_en   <= 1'b0;
      mem_write_data <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (accept) begin
        cnt      <= {cmd_len == 8'd0, cmd_len};
        dir_wr   <= cmd_write;
        stop_q   <= 1'b0;
        lost_q   <= 1'b0;
        gcnt     <= '0;
        phase_hi <= 1'b0;
      end else begin
        if (busy) begin
          stop_q <= stop_q || abort || gnt_lost;
          lost_q <= lost_q || gnt_lost;
        end
        if (byte_end) cnt <= cnt - 9'd1;
        if (state == REQ) gcnt <= gcnt + GW'(1);
      end
      if (state == RD_WAIT) lat <= lat + LW'(1);
      else lat <= '0;
      if (sample) begin
        phase_hi <= !phase_hi;
        if (phase_hi) rd_data[7:4] <= nib;
        else rd_data[3:0] <= nib;
      end
      if (capture) wr_hi <= wr_data[7:4];
      // Any way into DONE other than completing the last byte counts as aborted.
      if (state_nxt == DONE) aborted_q <= !(byte_end && cnt == 9'd1);
      mem_write_en <= 1'b0;
      case (state_nxt)
        RD_ADDR: begin
          guard_q <= guard_nxt;
          if (!guard_nxt) mem_addr <= ptr_nxt;
        end
        WR_LO: begin
          mem_write_en   <= 1'b1;
          mem_addr       <= ptr_nxt;
          mem_write_data <= wr_data[3:0];
        end
        WR_HI: begin
          mem_write_en   <= 1'b1;
          mem_addr       <= ptr_nxt;
          mem_write_data <= wr_hi;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_host_master.sv
// Scoreboard bench for mem_bus_host_master: reference nibble memory, decoupled monitor, random bursts.
module tb_mem_bus_host_master;
  localparam int GT = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, abort = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [7:0]  wr_data = '0, rd_data;
  logic        wr_valid = 1'b0, rd_ready = 1'b0, bus_gnt = 1'b0;
  logic        cmd_ready, wr_ready, rd_valid, busy, done, aborted, bus_req, mem_write_en;
  logic [11:0] mem_addr;
  logic [3:0]  mem_write_data, mem_read_data, state_dbg;

  mem_bus_host_master #(.RD_LATENCY(1), .GNT_TIMEOUT(GT)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .abort(abort),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .aborted(aborted), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [3:0]  ref_mem [4096];
  logic [3:0]  slv [4096];
  logic [7:0]  exp_q [$];
  logic [15:0] exp_w_q [$];
  logic        exp_done_q [$];
  logic [7:0]  wr_src_q [$];
  int          n_checks = 0, n_fail = 0, done_seen = 0, gdelay = 0;
  bit          hold_rd = 1'b0, gnt_block = 1'b0, wr_fire = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_msg(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Bus responder: registered read (1 cycle), clear-on-read factor registers at 0xF00-0xF02.
  always @(posedge clk) begin
    if (!reset_n) begin
      mem_read_data <= 4'h0;
      for (int i = 0; i < 4096; i++) slv[i] <= ref_mem[i];
    end else if (bus_gnt && mem_write_en) begin
      slv[mem_addr] <= mem_write_data;
    end else if (bus_gnt) begin
      mem_read_data <= slv[mem_addr];
      if (mem_addr >= 12'hF00 && mem_addr <= 12'hF02) slv[mem_addr] <= 4'h0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transfer.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) fail_msg("rd_extra: unexpected read byte");
        else check("rd_data", rd_data, exp_q.pop_front());
      end
      if (mem_write_en && bus_gnt) begin
        if (exp_w_q.size() == 0) fail_msg("bus_write_extra: unexpected bus write");
        else check("bus_write", {mem_addr, mem_write_data}, exp_w_q.pop_front());
      end
      if (done) begin
        if (exp_done_q.size() == 0) fail_msg("done_extra: unexpected done");
        else begin
          check("aborted", aborted, exp_done_q.pop_front());
          check("bytes_left_at_done", exp_q.size(), 0);
        end
        done_seen++;
      end
    end
    wr_fire = wr_valid && wr_ready;
  end

  // Host data driver and grant model, updated just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (wr_fire && wr_src_q.size() > 0) void'(wr_src_q.pop_front());
    wr_valid = (wr_src_q.size() > 0);
    wr_data  = (wr_src_q.size() > 0) ? wr_src_q[0] : 8'h00;
    rd_ready = hold_rd ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (gnt_block || !bus_req) begin
      bus_gnt = 1'b0;
      gdelay  = $urandom_range(0, 3);
    end else if (!bus_gnt) begin
      if (gdelay == 0) bus_gnt = 1'b1;
      else gdelay--;
    end
  end

  // Builds expectations from the reference memory, then offers the command.
  task automatic issue(input bit wr, input logic [11:0] a, input logic [7:0] len, input int wbyte);
    int n;
    logic [11:0] p, p1;
    logic [7:0] b;
    bit ok;
    n = (len == 8'd0) ? 256 : int'(len);
    p = a;
    for (int i = 0; i < n; i++) begin
      p1 = p + 12'd1;
      if (wr) begin
        b = (wbyte >= 0) ? 8'(wbyte) : 8'($urandom);
        wr_src_q.push_back(b);
        exp_w_q.push_back({p, b[3:0]});
        exp_w_q.push_back({p1, b[7:4]});
        ref_mem[p]  = b[3:0];
        ref_mem[p1] = b[7:4];
      end else begin
        exp_q.push_back({ref_mem[p1], ref_mem[p]});
      end
      p = p1 + 12'd1;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = len;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    if (!ok) fail_msg("cmd_accept_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    int start;
    start  = done_seen;
    cycles = 0;
    while (done_seen == start && cycles < budget) begin
      @(posedge clk);
      cycles++;
    end
    if (done_seen == start) fail_msg("done_timeout");
  endtask

  task automatic wait_gnt();
    int c;
    c = 0;
    while (c < 50) begin
      @(negedge clk);
      if (bus_gnt) break;
      c++;
    end
    if (!bus_gnt) fail_msg("gnt_wait_timeout");
  endtask

  initial begin
    int cyc, saved;
    logic [7:0] len;
    logic [11:0] a;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 4'($urandom);
    ref_mem[12'h010] = 4'h1; ref_mem[12'h011] = 4'h2;
    ref_mem[12'h012] = 4'h3; ref_mem[12'h013] = 4'h4;
    ref_mem[12'hFFF] = 4'h9; ref_mem[12'h000] = 4'h6;
    ref_mem[12'hF00] = 4'h3; ref_mem[12'hF01] = 4'h0; ref_mem[12'hF02] = 4'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_bus_req", bus_req, 0);
    check("reset_done", done, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_mem_write_en", mem_write_en, 0);
    check("reset_mem_addr", mem_addr, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_ready", cmd_ready, 1);

    // Directed read burst.
    exp_done_q.push_back(1'b0);
    issue(1'b0, 12'h010, 8'd2, -1);
    wait_done(200, cyc);

    // Directed write burst at the top of RAM, then read it back.
    exp_done_q.push_back(1'b0);
    issue(1'b1, 12'h27E, 8'd1, 8'hA5);
    wait_done(200, cyc);
    exp_done_q.push_back(1'b0);
    issue(1'b0, 12'h27E, 8'd1, -1);
    wait_done(200, cyc);
    check("readback_ref_27e", {ref_mem[12'h27F], ref_mem[12'h27E]}, 8'hA5);

    // Address wrap 0xFFF -> 0x000.
    exp_done_q.push_back(1'b0);
    issue(1'b0, 12'hFFF, 8'd1, -1);
    wait_done(200, cyc);
    @(negedge clk);
    check("wrap_mem_addr", mem_addr, 12'h000);

    // Reset in the middle of a burst: no done, back to idle.
    hold_rd = 1'b1;
    saved = done_seen;
    issue(1'b0, 12'h100, 8'd8, -1);
    wait_gnt();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midreset_busy", busy, 0);
    check("midreset_bus_req", bus_req, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) @(posedge clk);
    check("midreset_no_done", done_seen, saved);
    check("midreset_cmd_ready", cmd_ready, 1);

    // Backpressure with abort inside the first byte.
    exp_done_q.push_back(1'b1);
    issue(1'b0, 12'h080, 8'd4, -1);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    wait_gnt();
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("backpressure_rd_valid_held", rd_valid, 1);
    hold_rd = 1'b0;
    wait_done(200, cyc);

    // Grant never arrives.
    gnt_block = 1'b1;
    exp_done_q.push_back(1'b1);
    issue(1'b0, 12'h040, 8'd2, -1);
    exp_q.delete();
    wait_done(40, cyc);
    check("gnt_timeout_within_10", (cyc <= 10), 1);
    @(negedge clk);
    check("gnt_timeout_bus_req_low", bus_req, 0);
    check("gnt_timeout_busy_low", busy, 0);
    gnt_block = 1'b0;

    // Random bursts in RAM, plus one 256-byte read.
    for (int k = 0; k < 16; k++) begin
      len = 8'($urandom_range(1, 8));
      a   = 12'($urandom_range(0, 12'h280 - 2 * int'(len)));
      exp_done_q.push_back(1'b0);
      issue(1'($urandom_range(0, 1)), a, len, -1);
      wait_done(500, cyc);
    end
    exp_done_q.push_back(1'b0);
    issue(1'b0, 12'h000, 8'd0, -1);
    wait_done(5000, cyc);

    // Interrupt factor read at 0xF00.
    exp_done_q.push_back(1'b0);
    issue(1'b0, 12'hF00, 8'd1, -1);
`ifdef MEM_BUS_IO_READ_GUARD_EN
    void'(exp_q.pop_back());
    exp_q.push_back(8'h00);
`endif
    wait_done(200, cyc);
    repeat (3) @(posedge clk);
`ifdef MEM_BUS_IO_READ_GUARD_EN
    check("factor_preserved", slv[12'hF00], 4'h3);
`else
    check("factor_cleared", slv[12'hF00], 4'h0);
`endif

    repeat (5) @(posedge clk);
    check("write_queue_drained", exp_w_q.size(), 0);
    check("done_queue_drained", exp_done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
